// File: rtl/flappy_pkg.sv
// ---------------------------------------------------------------------------
// flappy_pkg
//   Types and screen constants used by the Flappy Bird blocks
//   (pipe_generator, display_manager, bird_physics).
//   coord_t  : 11-bit unsigned pixel coordinate
//   SCREEN_W : visible width in pixels
//   SCREEN_H : visible height in pixels
//   GAP_H    : vertical size of the gap in a pipe
// ---------------------------------------------------------------------------
package flappy_pkg;

  typedef logic [10:0] coord_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int GAP_H    = 120;

endpackage

// File: rtl/lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
//   Free-running 16-bit Fibonacci LFSR using taps 16,14,13,11.
//   It advances on every clock edge and has no enable input.
//   Ports:
//     clk   in   1   clock
//     reset in   1   asynchronous active-low reset; loads SEED
//     q     out  16  current LFSR state
//   Parameter:
//     SEED  reset value; it must be non-zero or the register locks up at 0
// ---------------------------------------------------------------------------
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] state_q;
  logic [15:0] state_d;
  logic        feedback;

  // Tap 16 is bit 15, tap 14 is bit 13, tap 13 is bit 12 and tap 11 is bit 10.
  assign feedback = state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10];
  assign state_d  = {state_q[14:0], feedback};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign q = state_q;

endmodule

// File: rtl/pipe_generator.sv
// ---------------------------------------------------------------------------
// pipe_generator
//   Produces two scrolling pipes with random gap heights, plus a saturating
//   score of pipes passed by the bird.
//   Ports:
//     clk         in   1   system clock
//     reset       in   1   asynchronous active-low reset
//     tick        in   1   one-clock game-step strobe
//     enable      in   1   game running; ticks are ignored when low
//     bird_x      in   11  bird left-edge x, used for scoring
//     pipe1_x     out  11  pipe 1 x
//     pipe1_y     out  11  pipe 1 gap-top y
//     pipe2_x     out  11  pipe 2 x
//     pipe2_y     out  11  pipe 2 gap-top y
//     score       out  10  pipes passed, saturating at SCORE_MAX
//     score_pulse out  1   high for one clock whenever score changes
//   All outputs are registered.
//   Build option: define PIPE_SPEEDUP_EN to make the scroll speed increase
//   with the score as min(SPEED + score/10, 7). Without this macro the speed
//   is the constant SPEED.
// ---------------------------------------------------------------------------
module pipe_generator #(
  parameter int          SCREEN_W  = flappy_pkg::SCREEN_W,
  parameter int          SPACING   = 320,
  parameter int          GAP_MIN   = 100,
  parameter int          SPEED     = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          SCORE_MAX = 999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        enable,
  input  logic [10:0] bird_x,
  output logic [10:0] pipe1_x,
  output logic [10:0] pipe1_y,
  output logic [10:0] pipe2_x,
  output logic [10:0] pipe2_y,
  output logic [9:0]  score,
  output logic        score_pulse
);

  typedef flappy_pkg::coord_t coord_t;

  localparam coord_t X_WRAP = coord_t'(SCREEN_W - 1);
  localparam coord_t X1_RST = coord_t'(SCREEN_W - SPACING - 1);
  localparam coord_t X2_RST = coord_t'(SCREEN_W - 1);
  localparam coord_t Y1_RST = coord_t'(250);
  localparam coord_t Y2_RST = coord_t'(200);
  localparam coord_t Y_BASE = coord_t'(GAP_MIN);
  localparam coord_t S_MAX  = coord_t'(SCORE_MAX);

  logic [15:0] lfsr_q;
  logic [7:0]  rnd [2];
  coord_t      x_q [2];
  coord_t      x_d [2];
  coord_t      y_q [2];
  coord_t      y_d [2];
  logic [1:0]  hit;
  logic [9:0]  score_q;
  logic [9:0]  score_d;
  logic        pulse_q;
  logic        pulse_d;
  coord_t      score_sum;
  coord_t      spd;
  logic        step;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  // Each pipe takes a different byte, so two pipes that wrap on the same
  // step still get different gap heights.
  assign rnd[0] = lfsr_q[7:0];
  assign rnd[1] = lfsr_q[15:8];
  assign step   = tick & enable;

`ifdef PIPE_SPEEDUP_EN
  logic [2:0]  speed_q;
  logic [2:0]  speed_d;
  logic [9:0]  boost;
  coord_t      speed_raw;

  // The speed is computed from the registered score, so a speed change
  // takes effect one cycle after the score changes.
  always_comb begin
    boost     = score_q / 10'd10;
    speed_raw = coord_t'(SPEED) + {1'b0, boost};
    speed_d   = (speed_raw > coord_t'(7)) ? 3'd7 : speed_raw[2:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      speed_q <= 3'(SPEED);
    end else begin
      speed_q <= speed_d;
    end
  end

  assign spd = {8'd0, speed_q};
`else
  assign spd = coord_t'(SPEED);
`endif

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      x_d[i] = x_q[i];
      y_d[i] = y_q[i];
      hit[i] = 1'b0;
      if (step) begin
        // Compare against the old x before subtracting, so an x value that
        // has wrapped below zero is never stored.
        if (x_q[i] < spd) begin
          x_d[i] = X_WRAP;
          y_d[i] = Y_BASE + {3'b000, rnd[i]};
        end else begin
          x_d[i] = x_q[i] - spd;
          // A pipe scores when it moves past the bird; a wrap never scores.
          hit[i] = (x_q[i] > bird_x) && (x_d[i] <= bird_x);
        end
      end
    end
    score_sum = {1'b0, score_q} + {10'd0, hit[0]} + {10'd0, hit[1]};
    if (score_sum > S_MAX) begin
      score_sum = S_MAX;
    end
    score_d = score_sum[9:0];
    // When the score is saturated no pulse is produced.
    pulse_d = (score_d != score_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q[0]  <= X1_RST;
      x_q[1]  <= X2_RST;
      y_q[0]  <= Y1_RST;
      y_q[1]  <= Y2_RST;
      score_q <= 10'd0;
      pulse_q <= 1'b0;
    end else begin
      x_q[0]  <= x_d[0];
      x_q[1]  <= x_d[1];
      y_q[0]  <= y_d[0];
      y_q[1]  <= y_d[1];
      score_q <= score_d;
      pulse_q <= pulse_d;
    end
  end

  assign pipe1_x     = x_q[0];
  assign pipe1_y     = y_q[0];
  assign pipe2_x     = x_q[1];
  assign pipe2_y     = y_q[1];
  assign score       = score_q;
  assign score_pulse = pulse_q;

endmodule
